piso_tx_8b: RTL and testbench
=============================

PISO_TX_8B -- requirements
Module: piso_tx_8b

Interface
REQ-001 Parameter WIDTH, default 8, number of data bits per frame (legal range 2..16).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset: rst, synchronous, active-high; clock clk.
REQ-004 data_in  input  WIDTH  parallel word to transmit.
REQ-005 load_valid  input  1  data_in is valid this cycle.
REQ-006 load_ready  output  1  block accepts a word this cycle.
REQ-007 sout  output  1  serial data bit, LSB first.
REQ-008 sout_valid  output  1  sout carries a frame bit this cycle.
REQ-009 sout_ready  input  1  downstream consumes sout this cycle.
REQ-010 busy  output  1  frame in progress.
REQ-011 done  output  1  one-cycle pulse after the last bit is consumed.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT and DONE; encoding SHALL be internal.
REQ-013 In IDLE the block SHALL drive load_ready=1, busy=0, sout_valid=0, sout=0 and done=0.
REQ-014 Accept: load_valid=1 in IDLE SHALL capture data_in into the shift register, clear the bit counter and move to SHIFT on the next edge.
REQ-015 Latency: the first bit (data_in[0]) SHALL appear on sout with sout_valid=1 in the cycle immediately after the accept.
REQ-016 In SHIFT: load_ready=0, busy=1, sout_valid=1, sout=current shift-register LSB.
REQ-017 The register SHALL shift right and the counter SHALL increment only on edges where sout_valid=1 and sout_ready=1; with sout_ready=0 sout and the counter SHALL hold, with no limit on stall length.
REQ-018 When the last frame bit (counter = frame length-1) is consumed, the FSM SHALL move to DONE.
REQ-019 DONE SHALL last exactly one cycle, with done=1, busy=1, sout_valid=0 and load_ready=0, then return to IDLE.
REQ-020 load_valid outside IDLE SHALL be ignored; data_in changes after the accept SHALL NOT affect the frame in flight.
REQ-021 Back-to-back: a load_valid in the IDLE cycle following DONE SHALL be accepted; the minimum frame period is frame length+2 cycles.
REQ-022 The counter SHALL be wide enough for frame length+1 and SHALL NOT wrap within a frame.

Reset
REQ-023 rst=1 SHALL force IDLE, a zero shift register, a zero counter, load_ready=1, sout=0, sout_valid=0, busy=0 and done=0 on the next edge.
REQ-024 rst SHALL take priority over load_valid and sout_ready in the same cycle.
REQ-025 rst asserted in SHIFT SHALL abort the frame with no done pulse; the remaining bits SHALL be discarded.

Configuration
REQ-026 Macro PISO_TX_PARITY_EN SHALL control parity.
- Defined: frame length = WIDTH+1; an even-parity bit (XOR of the captured word) SHALL be sent after data bit WIDTH-1.
- Not defined: frame length = WIDTH, with no parity logic.

Structure
REQ-027 Package piso_tx_pkg SHALL hold the state enum typedef, the default WIDTH constant, and the counter-width constant (ceil(log2(WIDTH+2))).
REQ-028 The bit counter (clear, enable, terminal-count compare) SHALL be a single sub-module, piso_bit_cnt; the FSM and shift register SHALL stay in piso_tx_8b.

Verification
REQ-029 Basic: reset, then load 0xA5 with sout_ready=1 -> sout sequence 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting 1 cycle after the accept, then done=1 for one cycle.
REQ-030 Stall: load 0x3C and drop sout_ready for 3 cycles after bit 2 -> sout holds 1 and sout_valid stays 1 for 3 cycles, the full byte is still correct, and done is delayed by 3 cycles.
REQ-031 Ignore: pulse load_valid with 0xFF during SHIFT of 0x01 -> the output frame is 1,0,0,0,0,0,0,0 and load_ready=0 throughout.
REQ-032 Reset mid-frame: assert rst after bit 4 of 0x81 -> the next cycle sout_valid=0, busy=0, done never pulses, and load_ready=1.
REQ-033 Parity (PISO_TX_PARITY_EN defined): load 0x07 -> 8 data bits, then parity bit 1, then done; with 0x03 the parity bit is 0.
REQ-034 Back-to-back: hold load_valid=1 with 0x55 then 0xAA -> the second accept occurs in the IDLE cycle after DONE, and frames are separated by exactly 2 idle-output cycles.

Source files
------------

// File: rtl/piso_tx_pkg.sv
// piso_tx_pkg: state type and sizing constants shared by the PISO transmitter
package piso_tx_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  localparam int DEF_WIDTH = 8;
  localparam int CNT_W = $clog2(DEF_WIDTH + 2);
  function automatic int cnt_w(input int width);
    return $clog2(width + 2);
  endfunction
endpackage

// File: rtl/piso_bit_cnt.sv
// piso_bit_cnt: frame bit counter with clear, enable and terminal-count flag
module piso_bit_cnt #(
  parameter int CW = 4,
  parameter int LAST = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic last_o
);
  logic [CW-1:0] cnt_q, cnt_d;
  // clear wins over count; hold otherwise
  always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
  // count register
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign last_o = cnt_q == CW'(LAST);
endmodule

// File: rtl/piso_tx_8b.sv
// piso_tx_8b: LSB-first parallel-to-serial transmitter; PISO_TX_PARITY_EN appends an even-parity bit
module piso_tx_8b
  import piso_tx_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic             busy,
  output logic             done
);
`ifdef PISO_TX_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif
  state_e state_q, state_d;
  logic [FL-1:0] sh_q, sh_d, frame;
  logic accept, last;
`ifdef PISO_TX_PARITY_EN
  assign frame = {^data_in, data_in};
`else
  assign frame = data_in;
`endif
  assign accept = state_q == IDLE && load_valid;
  piso_bit_cnt #(.CW(cnt_w(WIDTH)), .LAST(FL - 1)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (accept),
    .en_i  (state_q == SHIFT && sout_ready),
    .last_o(last)
  );
  // next state, shift register next value and Moore outputs
  always_comb begin
    state_d = state_q;
    sh_d = sh_q;
    load_ready = 1'b0;
    busy = 1'b0;
    sout_valid = 1'b0;
    sout = 1'b0;
    done = 1'b0;
    case (state_q)
      IDLE: begin
        load_ready = 1'b1;
        state_d = load_valid ? SHIFT : IDLE;
        sh_d = load_valid ? frame : sh_q;
      end
      SHIFT: begin
        busy = 1'b1;
        sout_valid = 1'b1;
        sout = sh_q[0];
        sh_d = sout_ready ? {1'b0, sh_q[FL-1:1]} : sh_q;
        state_d = sout_ready && last ? DONE : SHIFT;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and shift registers
  always_ff @(posedge clk) begin
    state_q <= rst ? IDLE : state_d;
    sh_q <= rst ? '0 : sh_d;
  end
endmodule

// File: tb/tb_piso_tx_8b.sv
// tb_piso_tx_8b: directed and random frames checked against a bit-queue reference model
module tb_piso_tx_8b;
  localparam int W = 8;
`ifdef PISO_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, load_valid = 1'b0, sout_ready = 1'b0;
  logic [W-1:0] data_in = '0;
  logic load_ready, sout, sout_valid, busy, done;
  int n_vec = 0, n_err = 0;
  bit m_done = 1'b0;
  bit q[$];

  piso_tx_8b #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .sout      (sout),
    .sout_valid(sout_valid),
    .sout_ready(sout_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic lv, input logic [W-1:0] d, input logic sr);
    bit sending;
    rst = r;
    load_valid = lv;
    data_in = d;
    sout_ready = sr;
    sending = !m_done && q.size() != 0;
    chk("load_ready", 32'(load_ready), 32'(!m_done && q.size() == 0));
    chk("busy", 32'(busy), 32'(m_done || q.size() != 0));
    chk("sout_valid", 32'(sout_valid), 32'(sending));
    chk("sout", 32'(sout), sending ? 32'(q[0]) : 32'd0);
    chk("done", 32'(done), 32'(m_done));
    @(posedge clk);
    if (r) begin
      q.delete();
      m_done = 1'b0;
    end else if (m_done) m_done = 1'b0;
    else if (q.size() != 0) begin
      if (sr) begin
        void'(q.pop_front());
        if (q.size() == 0) m_done = 1'b1;
      end
    end else if (lv) begin
      for (int i = 0; i < W; i++) q.push_back(d[i]);
      if (PAR) q.push_back(^d);
    end
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    cyc(1'b1, 1'b1, 8'hFF, 1'b1);
    cyc(1'b0, 1'b1, 8'hA5, 1'b1);
    repeat (12) cyc(1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 1'b1, 8'h3C, 1'b1);
    repeat (3) cyc(1'b0, 1'b0, 8'h00, 1'b1);
    repeat (3) cyc(1'b0, 1'b0, 8'h00, 1'b0);
    repeat (9) cyc(1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 1'b1, 8'h01, 1'b1);
    for (int i = 0; i < 11; i++) cyc(1'b0, i % 3 == 0, 8'hFF, 1'b1);
    cyc(1'b0, 1'b1, 8'h81, 1'b1);
    repeat (4) cyc(1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1'b1, 1'b0, 8'h00, 1'b1);
    repeat (4) cyc(1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 1'b1, 8'h07, 1'b1);
    repeat (11) cyc(1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 1'b1, 8'h03, 1'b1);
    repeat (11) cyc(1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 1'b1, 8'h55, 1'b1);
    repeat (24) cyc(1'b0, 1'b1, 8'hAA, 1'b1);
    repeat (3000)
      cyc($urandom_range(63) == 0, $urandom_range(1) == 1, W'($urandom), $urandom_range(3) != 0);
    cyc(1'b1, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
